// File: rtl/ctrl_coef_seq_if.sv
// ctrl_coef_seq_if: request inputs and counter/accumulator controls of the coefficient sequencer
interface ctrl_coef_seq_if #(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int TAPS_WIDTH = 8,
  parameter int PHASE_WIDTH = 8
);
  logic start;
  logic abort;
  logic [PHASE_WIDTH-1:0] phase;
  logic [TAPS_WIDTH-1:0] taps_per_phase;
  logic [DATA_ADDRESS_WIDTH-1:0] coef_base;
  logic ctr_clr;
  logic ctr_load;
  logic ctr_cnt;
  logic [DATA_ADDRESS_WIDTH-1:0] coef_ptr;
  logic mac_first;
  logic mac_last;
  logic busy;
  logic done;
  logic err;
  modport master (
    output start, abort, phase, taps_per_phase, coef_base,
    input ctr_clr, ctr_load, ctr_cnt, coef_ptr, mac_first, mac_last, busy, done, err
  );
  modport slave (
    input start, abort, phase, taps_per_phase, coef_base,
    output ctr_clr, ctr_load, ctr_cnt, coef_ptr, mac_first, mac_last, busy, done, err
  );
endinterface

// File: rtl/ctrl_coef_seq.sv
// ctrl_coef_seq: per-sample coefficient sequencer issuing one LOAD then taps COUNT cycles
module ctrl_coef_seq #(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int TAPS_WIDTH = 8,
  parameter int PHASE_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  ctrl_coef_seq_if.slave io_bus
);
  localparam int DAW = DATA_ADDRESS_WIDTH;
  localparam int TW = TAPS_WIDTH;
  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;
  state_t r_state;
  logic [TW-1:0] r_taps, r_tap;
  logic [DAW-1:0] r_ptr;
  logic r_clr, r_load, r_cnt, r_first, r_last, r_busy, r_done, r_err;
  logic [DAW-1:0] w_ptr;
  // phase offset wraps modulo the address space, so narrowing before multiplying is exact
  assign w_ptr = DAW'(io_bus.coef_base) + DAW'(io_bus.phase) * DAW'(io_bus.taps_per_phase);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_taps <= '0;
      r_tap <= '0;
      r_ptr <= '0;
      r_clr <= 1'b0;
      r_load <= 1'b0;
      r_cnt <= 1'b0;
      r_first <= 1'b0;
      r_last <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      r_load <= 1'b0;
      r_first <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      if (io_bus.abort) begin
        r_state <= IDLE;
        r_clr <= 1'b1;
        r_cnt <= 1'b0;
        r_last <= 1'b0;
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (io_bus.start && io_bus.taps_per_phase != '0) begin
              r_taps <= io_bus.taps_per_phase;
              r_ptr <= w_ptr;
              r_state <= LOAD;
              r_load <= 1'b1;
              r_busy <= 1'b1;
            end else begin
              r_err <= io_bus.start;
            end
          end
          LOAD: begin
            r_err <= io_bus.start;
            r_tap <= r_taps - 1'b1;
            r_state <= COUNT;
            r_cnt <= 1'b1;
            r_first <= 1'b1;
            r_last <= r_taps == TW'(1);
          end
          COUNT: begin
            r_err <= io_bus.start;
            if (r_tap == '0) begin
              r_state <= DONE;
              r_cnt <= 1'b0;
              r_last <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_tap <= r_tap - 1'b1;
              r_last <= r_tap == TW'(1);
            end
          end
          DONE: begin
            r_err <= io_bus.start;
            r_state <= IDLE;
            r_busy <= 1'b0;
          end
        endcase
      end
    end
  end
  assign io_bus.ctr_clr = r_clr;
  assign io_bus.ctr_load = r_load;
  assign io_bus.ctr_cnt = r_cnt;
  assign io_bus.coef_ptr = r_ptr;
  assign io_bus.mac_first = r_first;
  assign io_bus.mac_last = r_last;
  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.err = r_err;
endmodule

// File: tb/tb_ctrl_coef_seq.sv
// tb_ctrl_coef_seq: randomized and directed checks against a run-position model of the sequencer
module tb_ctrl_coef_seq;
  localparam int DAW = 12, TW = 8, PW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ctrl_coef_seq_if #(.DATA_ADDRESS_WIDTH(DAW), .TAPS_WIDTH(TW), .PHASE_WIDTH(PW)) bus ();
  ctrl_coef_seq #(.DATA_ADDRESS_WIDTH(DAW), .TAPS_WIDTH(TW), .PHASE_WIDTH(PW)) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );
  int tests = 0, fails = 0;
  bit m_run, e_clr, e_err;
  int m_k, m_taps, m_ptr;
  int a_addr, n_cnt, f_addr, l_addr, lp, fl_seen, err_cnt, busy_cnt, done_cnt;
  int cyc, c_load, c_first, c_last, c_done;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // model tracks only "in a run, k cycles after acceptance"
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_k = 0; m_ptr = 0; m_taps = 0; e_clr = 0; e_err = 0;
    end else begin
      e_clr = 0; e_err = 0;
      if (bus.abort) begin
        e_clr = 1; m_run = 0;
      end else if (m_run) begin
        e_err = bus.start;
        m_k++;
        if (m_k > m_taps + 2) m_run = 0;
      end else if (bus.start) begin
        if (bus.taps_per_phase == 0) e_err = 1;
        else begin
          m_run = 1; m_k = 1; m_taps = int'(bus.taps_per_phase);
          m_ptr = (int'(bus.coef_base) + int'(bus.phase) * int'(bus.taps_per_phase)) % 4096;
        end
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    cyc++;
    chk("clr", bus.ctr_clr, e_clr);
    chk("err", bus.err, e_err);
    chk("busy", bus.busy, m_run);
    chk("load", bus.ctr_load, m_run && m_k == 1);
    chk("cnt", bus.ctr_cnt, m_run && m_k >= 2 && m_k <= m_taps + 1);
    chk("first", bus.mac_first, m_run && m_k == 2);
    chk("last", bus.mac_last, m_run && m_k == m_taps + 1);
    chk("done", bus.done, m_run && m_k == m_taps + 2);
    chk("coef_ptr", bus.coef_ptr, m_ptr);
    if (bus.ctr_clr) a_addr = 0;
    if (bus.ctr_load) begin
      a_addr = int'(bus.coef_ptr); lp = a_addr; n_cnt = 0; c_load = cyc;
    end
    if (bus.ctr_cnt) begin
      chk("addr", a_addr, (m_ptr + m_k - 2) % 4096);
      if (n_cnt == 0) f_addr = a_addr;
      l_addr = a_addr;
      n_cnt++;
      a_addr = (a_addr + 1) % 4096;
    end
    if (bus.mac_first) c_first = cyc;
    if (bus.mac_last) c_last = cyc;
    if (bus.mac_first && bus.mac_last) fl_seen++;
    if (bus.err) err_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.done) begin done_cnt++; c_done = cyc; end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic clear();
    err_cnt = 0; busy_cnt = 0; done_cnt = 0; fl_seen = 0; n_cnt = 0;
  endtask
  task automatic go(input int b, input int p, input int t);
    bus.coef_base = DAW'(b); bus.phase = PW'(p); bus.taps_per_phase = TW'(t); bus.start = 1;
    tick();
    bus.start = 0;
    bus.coef_base = DAW'($urandom); bus.phase = PW'($urandom); bus.taps_per_phase = TW'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    tick();
    while (bus.busy && n < 400) begin tick(); n++; end
    chk("timeout", n < 400, 1);
  endtask
  initial begin
    bus.start = 0; bus.abort = 0; bus.phase = 0; bus.taps_per_phase = 0; bus.coef_base = 0;
    repeat (2) tick();
    rst = 0;
    clear();
    repeat (10) tick();
    chk("idle_busy", busy_cnt, 0);
    chk("idle_ptr", bus.coef_ptr, 0);
    clear(); go(12'h100, 3, 8); wait_idle();
    chk("nom_ptr", lp, 12'h118);
    chk("nom_ncnt", n_cnt, 8);
    chk("nom_first_addr", f_addr, 12'h118);
    chk("nom_last_addr", l_addr, 12'h11F);
    chk("nom_first_lat", c_first - c_load, 1);
    chk("nom_last_lat", c_last - c_load, 8);
    chk("nom_done_lat", c_done - c_load, 9);
    chk("nom_done_cnt", done_cnt, 1);
    clear(); go(12'h007, 0, 1); wait_idle();
    chk("t1_ncnt", n_cnt, 1);
    chk("t1_fl", fl_seen, 1);
    chk("t1_ptr", lp, 7);
    chk("t1_done", done_cnt, 1);
    clear(); go(12'h005, 2, 0); repeat (4) tick();
    chk("t0_err", err_cnt, 1);
    chk("t0_busy", busy_cnt, 0);
    clear(); go(12'hFF0, 1, 32); wait_idle();
    chk("wrap_ptr", lp, 12'h010);
    chk("wrap_ncnt", n_cnt, 32);
    chk("wrap_first", f_addr, 12'h010);
    chk("wrap_last", l_addr, 12'h02F);
    clear(); go(12'h200, 2, 6); tick();
    bus.start = 1; bus.taps_per_phase = 3; tick(); bus.start = 0;
    wait_idle();
    chk("col_err", err_cnt, 1);
    chk("col_ncnt", n_cnt, 6);
    chk("col_ptr", lp, 12'h20C);
    chk("col_last", l_addr, 12'h211);
    chk("col_done", done_cnt, 1);
    clear(); go(12'h050, 1, 8); repeat (3) tick();
    bus.abort = 1; tick(); bus.abort = 0;
    chk("abt_clr", bus.ctr_clr, 1);
    chk("abt_busy", bus.busy, 0);
    chk("abt_ncnt", n_cnt, 3);
    repeat (12) tick();
    chk("abt_done", done_cnt, 0);
    clear();
    bus.start = 1; bus.abort = 1; bus.taps_per_phase = 4; tick(); bus.start = 0; bus.abort = 0;
    chk("as_clr", bus.ctr_clr, 1);
    repeat (6) tick();
    chk("as_err", err_cnt, 0);
    chk("as_busy", busy_cnt, 0);
    go(12'h300, 1, 8); repeat (2) tick();
    #2 rst = 1;
    #1;
    chk("rst_cnt", bus.ctr_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_first", bus.mac_first, 0);
    chk("rst_ptr", bus.coef_ptr, 0);
    tick(); rst = 0; tick();
    clear(); go(12'h040, 2, 5); wait_idle();
    chk("post_ncnt", n_cnt, 5);
    chk("post_ptr", lp, 12'h04A);
    chk("post_done", done_cnt, 1);
    for (int i = 0; i < 2000; i++) begin
      bus.start = ($urandom % 4) == 0;
      bus.abort = ($urandom % 25) == 0;
      bus.taps_per_phase = ($urandom % 16 == 0) ? TW'($urandom) : TW'($urandom % 12);
      bus.phase = PW'($urandom);
      bus.coef_base = DAW'($urandom);
      tick();
    end
    bus.start = 0; bus.abort = 0;
    repeat (300) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
